// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - ALU reservation station with age-ordered dual issue select
module alu_issue_scheduler #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 128,
  parameter int WAKE_N    = 4,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [1:0]                enq_wen_i,
  input  logic [2*PAYLOAD_W-1:0]    enq_payload_i,
  input  logic [2*TAG_W-1:0]        enq_prs1_i,
  input  logic [1:0]                enq_prs1_rdy_i,
  input  logic [2*TAG_W-1:0]        enq_prs2_i,
  input  logic [1:0]                enq_prs2_rdy_i,
  input  logic [WAKE_N-1:0]         wake_valid_i,
  input  logic [WAKE_N*TAG_W-1:0]   wake_tag_i,
  output logic [1:0]                iss_valid_o,
  output logic [2*PAYLOAD_W-1:0]    iss_payload_o,
  input  logic [1:0]                iss_ack_i,
  output logic [CNT_W-1:0]          count_o,
  output logic                      almost_full_o,
  output logic                      overflow_err_o
);

  // Entry storage; age_q[i][j] = 1 means entry i is older than entry j.
  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0]                rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [DEPTH-1:0][TAG_W-1:0]     prs1_q, prs1_d, prs2_q, prs2_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [DEPTH-1:0][DEPTH-1:0]     age_q, age_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic                            almost_full_q, almost_full_d;
  logic                            overflow_q, overflow_d;

  logic [DEPTH-1:0] ready, sel0, sel1, rem;
  logic [DEPTH-1:0] a0_oh, a1_oh;
  logic             deq0, deq1;

  // True when any asserted wakeup lane carries this tag.
  function automatic logic wake_hit(input logic [TAG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_N; w++) begin
      if (wake_valid_i[w] && (wake_tag_i[w*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Pick the oldest ready entry for ALU0, then the oldest remaining one for ALU1.
  always_comb begin
    logic older;
    ready = valid_q & rdy1_q & rdy2_q;
    sel0  = '0;
    sel1  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && age_q[j][i]) older = 1'b1;
      end
      if (ready[i] && !older) sel0[i] = 1'b1;
    end
    rem = ready & ~sel0;
    for (int i = 0; i < DEPTH; i++) begin
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (rem[j] && age_q[j][i]) older = 1'b1;
      end
      if (rem[i] && !older) sel1[i] = 1'b1;
    end
  end

  // Drive issue ports; payload is forced to zero on an idle port.
  always_comb begin
    iss_valid_o   = {|sel1, |sel0};
    iss_payload_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel0[i]) iss_payload_o[0 +: PAYLOAD_W]         = payload_q[i];
      if (sel1[i]) iss_payload_o[PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
    end
  end

  // Allocate from entries free in registered state; port0 first, port1 next.
  always_comb begin
    logic found;
    a0_oh = '0;
    a1_oh = '0;
    found = 1'b0;
    if (enq_wen_i[0]) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!valid_q[i] && !found) begin
          a0_oh[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    found = 1'b0;
    if (enq_wen_i[1]) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!valid_q[i] && !a0_oh[i] && !found) begin
          a1_oh[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign deq0 = iss_valid_o[0] & iss_ack_i[0];
  assign deq1 = iss_valid_o[1] & iss_ack_i[1];

  // Next state: wakeup, dequeue, enqueue, age update, occupancy; flush overrides all but overflow.
  always_comb begin
    valid_d       = valid_q;
    rdy1_d        = rdy1_q;
    rdy2_d        = rdy2_q;
    prs1_d        = prs1_q;
    prs2_d        = prs2_q;
    payload_d     = payload_q;
    age_d         = age_q;
    overflow_d    = overflow_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && wake_hit(prs1_q[i])) rdy1_d[i] = 1'b1;
      if (valid_q[i] && wake_hit(prs2_q[i])) rdy2_d[i] = 1'b1;
      if ((sel0[i] && deq0) || (sel1[i] && deq1)) valid_d[i] = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? a0_oh[i] : a1_oh[i]) begin
          valid_d[i]   = 1'b1;
          payload_d[i] = enq_payload_i[p*PAYLOAD_W +: PAYLOAD_W];
          prs1_d[i]    = enq_prs1_i[p*TAG_W +: TAG_W];
          prs2_d[i]    = enq_prs2_i[p*TAG_W +: TAG_W];
          rdy1_d[i]    = enq_prs1_rdy_i[p] || (enq_prs1_i[p*TAG_W +: TAG_W] == '0)
                         || wake_hit(enq_prs1_i[p*TAG_W +: TAG_W]);
          rdy2_d[i]    = enq_prs2_rdy_i[p] || (enq_prs2_i[p*TAG_W +: TAG_W] == '0)
                         || wake_hit(enq_prs2_i[p*TAG_W +: TAG_W]);
          age_d[i]     = (p == 0) ? a1_oh : '0;
        end
      end
    end

    // Columns are written after rows so the port0 row keeps its bit over the port1 entry.
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (a0_oh[i]) age_d[j][i] = valid_q[j];
        if (a1_oh[i]) age_d[j][i] = valid_q[j] | a0_oh[j];
      end
    end

    if ((enq_wen_i[0] && !(|a0_oh)) || (enq_wen_i[1] && !(|a1_oh))) overflow_d = 1'b1;

    count_d = count_q + CNT_W'(|a0_oh) + CNT_W'(|a1_oh) - CNT_W'(deq0) - CNT_W'(deq1);

    if (flush_i) begin
      valid_d    = '0;
      count_d    = '0;
      overflow_d = overflow_q;
    end
    almost_full_d = (count_d > CNT_W'(DEPTH - 2));
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      prs1_q        <= '0;
      prs2_q        <= '0;
      payload_q     <= '0;
      age_q         <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rdy1_q        <= rdy1_d;
      rdy2_q        <= rdy2_d;
      prs1_q        <= prs1_d;
      prs2_q        <= prs2_d;
      payload_q     <= payload_d;
      age_q         <= age_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign count_o        = count_q;
  assign almost_full_o  = almost_full_q;
  assign overflow_err_o = overflow_q;

endmodule
